// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller family.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 (F) first down to entry 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit active-low seven-segment scanner with tear-free frame-boundary updates.
// Optional brightness control (bright_i duty gating of an_n_o) when SEG_SCAN_BRIGHT_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int BLANK_CYCLES = 2,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
`ifdef SEG_SCAN_BRIGHT_EN
    input  logic [2:0]  bright_i,
`endif
    input  logic        upd_valid_i,
    output logic        upd_ready_o,
    input  logic [31:0] upd_digits_i,
    input  logic [7:0]  upd_dp_i,
    input  logic [7:0]  upd_mask_i,
    output logic [2:0]  sel_o,
    output logic [7:0]  an_n_o,
    output logic [6:0]  seg_n_o,
    output logic        dp_n_o,
    output logic        frame_done_o
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]       SEL_LAST   = 3'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;

    logic        pend_full_q, pend_full_d;
    logic [31:0] pend_digits_q, sh_digits_q;
    logic [7:0]  pend_dp_q, pend_mask_q, sh_dp_q, sh_mask_q;

    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [2:0]  sel_out_q, sel_out_d;
    logic        fd_q, fd_d;

    logic        show_last, wrap, xfer, commit, show_on, bright_ok;
    logic [6:0]  hex_seg;

    assign show_last = (state_q == SHOW) && (cnt_q == SHOW_LAST);
    assign wrap      = show_last && (sel_q == SEL_LAST);
    assign xfer      = upd_valid_i && !pend_full_q;
    // A full buffer commits at the frame wrap, or at once while the display is idle.
    assign commit    = pend_full_q && (wrap || (state_q == IDLE));
    assign show_on   = en_i && (state_q == SHOW);

`ifdef SEG_SCAN_BRIGHT_EN
    logic [2:0] phase;
    assign phase     = 3'((32'(cnt_q) * 32'd8) / 32'(CLK_DIV));
    assign bright_ok = (phase <= bright_i);
`else
    assign bright_ok = 1'b1;
`endif

    hex_to_seg7 u_hex (
        .hex_i   (sh_digits_q[{sel_q, 2'b00} +: 4]),
        .seg_n_o (hex_seg)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        pend_full_d = pend_full_q;
        an_d        = AN_OFF;
        seg_d       = SEG_OFF;
        dp_d        = 1'b1;
        sel_out_d   = en_i ? sel_q : 3'd0;
        fd_d        = en_i && wrap;

        if (xfer) begin
            pend_full_d = 1'b1;
        end else if (commit) begin
            pend_full_d = 1'b0;
        end

        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    sel_d = '0;
                    if (BLANK_CYCLES == 0) state_d = SHOW;
                    else                   state_d = BLANK;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (show_last) begin
                        cnt_d = '0;
                        sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
                        if (BLANK_CYCLES == 0) state_d = SHOW;
                        else                   state_d = BLANK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (show_on) begin
            seg_d = hex_seg;
            dp_d  = ~sh_dp_q[sel_q];
            if (sh_mask_q[sel_q] && bright_ok) begin
                an_d = ~(8'h01 << sel_q);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_full_q   <= 1'b0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_mask_q   <= '0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_mask_q     <= '0;
        end else begin
            pend_full_q <= pend_full_d;
            if (xfer) begin
                pend_digits_q <= upd_digits_i;
                pend_dp_q     <= upd_dp_i;
                pend_mask_q   <= upd_mask_i;
            end
            if (commit) begin
                sh_digits_q <= pend_digits_q;
                sh_dp_q     <= pend_dp_q;
                sh_mask_q   <= pend_mask_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            sel_out_q <= '0;
            fd_q      <= 1'b0;
        end else begin
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            sel_out_q <= sel_out_d;
            fd_q      <= fd_d;
        end
    end

    assign upd_ready_o  = ~pend_full_q;
    assign sel_o        = sel_out_q;
    assign an_n_o       = an_q;
    assign seg_n_o      = seg_q;
    assign dp_n_o       = dp_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=1, 8 digits).
module tb_seg_scan_ctrl;

    localparam int FRAME = 40;
    localparam int SLOT  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        updValid = 1'b0;
    logic        updReady;
    logic [31:0] updDigits = '0;
    logic [7:0]  updDp = '0;
    logic [7:0]  updMask = '0;
    logic [2:0]  sel;
    logic [7:0]  anN;
    logic [6:0]  segN;
    logic        dpN;
    logic        frameDone;

`ifdef SEG_SCAN_BRIGHT_EN
    logic [2:0]  brightMain = 3'd7;
    logic [2:0]  brightB = 3'd3;
    logic        enB = 1'b0;
    logic        readyB, dpNB, fdB;
    logic [2:0]  selB;
    logic [7:0]  anNB;
    logic [6:0]  segNB;
`endif

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(1), .NUM_DIGITS(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
`ifdef SEG_SCAN_BRIGHT_EN
        .bright_i     (brightMain),
`endif
        .upd_valid_i  (updValid),
        .upd_ready_o  (updReady),
        .upd_digits_i (updDigits),
        .upd_dp_i     (updDp),
        .upd_mask_i   (updMask),
        .sel_o        (sel),
        .an_n_o       (anN),
        .seg_n_o      (segN),
        .dp_n_o       (dpN),
        .frame_done_o (frameDone)
    );

`ifdef SEG_SCAN_BRIGHT_EN
    seg_scan_ctrl #(.CLK_DIV(8), .BLANK_CYCLES(1), .NUM_DIGITS(8)) dutB (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (enB),
        .bright_i     (brightB),
        .upd_valid_i  (updValid),
        .upd_ready_o  (readyB),
        .upd_digits_i (updDigits),
        .upd_dp_i     (updDp),
        .upd_mask_i   (updMask),
        .sel_o        (selB),
        .an_n_o       (anNB),
        .seg_n_o      (segNB),
        .dp_n_o       (dpNB),
        .frame_done_o (fdB)
    );
`endif

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit running = 0;
    bit checkEn = 0;
    bit pendFull = 0;
    bit swPending = 0;
    bit xferArmed = 0;
    logic [31:0] shDig = '0, pDig = '0, nxDig = '0, armDig = '0;
    logic [7:0]  shDp = '0, pDp = '0, nxDp = '0, armDp = '0;
    logic [7:0]  shMask = '0, pMask = '0, nxMask = '0, armMask = '0;

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic bit isWrap(input int c);
        return (c >= FRAME + 1) && ((c - 1) % FRAME == 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs for the cycle count since en rose: 1 idle + 1 blank, then 5-cycle slots.
    task automatic checkCycle();
        logic [7:0] eAn;
        logic [6:0] eSeg;
        logic       eDp, eFd;
        logic [2:0] eSel;
        int r, k, ph;
        eAn = 8'hFF; eSeg = 7'h7F; eDp = 1'b1; eSel = 3'd0; eFd = 1'b0;
        if (running && cyc >= 3) begin
            r  = (cyc - 3) % FRAME;
            k  = r / SLOT;
            ph = r % SLOT;
            if (ph < SLOT - 1) begin
                eSel = 3'(k);
                eSeg = hexSeg(shDig[4*k +: 4]);
                eDp  = ~shDp[k];
                if (shMask[k]) eAn = ~(8'h01 << k);
            end else begin
                eSel = 3'((k + 1) % 8);
            end
            eFd = isWrap(cyc);
        end
        checkOutput($sformatf("an_n@%0d", cyc), anN, eAn);
        checkOutput($sformatf("seg_n@%0d", cyc), segN, eSeg);
        checkOutput($sformatf("dp_n@%0d", cyc), dpN, eDp);
        checkOutput($sformatf("sel@%0d", cyc), sel, eSel);
        checkOutput($sformatf("frame_done@%0d", cyc), frameDone, eFd);
        checkOutput($sformatf("upd_ready@%0d", cyc), updReady, !pendFull);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (pendFull && !running) begin
            pendFull = 0;
            shDig = pDig; shDp = pDp; shMask = pMask;
        end else if (pendFull && running && isWrap(cyc)) begin
            pendFull = 0;
            swPending = 1;
            nxDig = pDig; nxDp = pDp; nxMask = pMask;
        end
        if (xferArmed) begin
            xferArmed = 0;
            pendFull = 1;
            pDig = armDig; pDp = armDp; pMask = armMask;
        end
        if (swPending && running && cyc >= FRAME + 3 && (cyc - 3) % FRAME == 0) begin
            swPending = 0;
            shDig = nxDig; shDp = nxDp; shMask = nxMask;
        end
        if (checkEn) checkCycle();
    endtask

    task automatic tickUntil(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input logic [31:0] dig, input logic [7:0] dp, input logic [7:0] mask);
        int waitN;
        waitN = 0;
        updDigits = dig;
        updDp = dp;
        updMask = mask;
        updValid = 1'b1;
        while (updReady !== 1'b1 && waitN < 200) begin
            tick();
            waitN++;
        end
        if (updReady !== 1'b1) begin
            checkOutput("push_ready_timeout", {31'b0, updReady}, 32'd1);
            updValid = 1'b0;
            return;
        end
        xferArmed = 1;
        armDig = dig; armDp = dp; armMask = mask;
        tick();
        updValid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sel"}, sel, 3'd0);
        checkOutput({tag, "_an_n"}, anN, 8'hFF);
        checkOutput({tag, "_seg_n"}, segN, 7'h7F);
        checkOutput({tag, "_dp_n"}, dpN, 1'b1);
        checkOutput({tag, "_upd_ready"}, updReady, 1'b1);
        checkOutput({tag, "_frame_done"}, frameDone, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Async reset before any clock edge.
        #2 rst = 1'b1;
        #1 checkResetValues("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkEn = 1;
        tick();
        tick();

        // Load in IDLE, then start scanning; shadow commits the cycle after the transfer.
        applyStimulus(32'h76543210, 8'h01, 8'hFF);
        tick();
        en = 1'b1; running = 1; cyc = 0;
        tickUntil(58);

        // Mid-frame update must not tear: digits 4-7 keep old values until the wrap.
        checkOutput("sel_before_push", sel, 3'd3);
        applyStimulus(32'h88888888, 8'h00, 8'hFF);
        tickUntil(122);

        // Masked frame with new digits and one decimal point.
        applyStimulus(32'hFEDCBA98, 8'h04, 8'h05);
        tickUntil(174);
        checkOutput("an_before_drop", anN, 8'hFB);
        checkOutput("seg_before_drop", segN, 7'b0001000);

        en = 1'b0; running = 0;
        repeat (3) tick();

        en = 1'b1; running = 1; cyc = 0;
        tickUntil(29);
        checkOutput("sel_digit5", sel, 3'd5);

        // Reset mid SHOW of digit 5, then restart with cleared shadow.
        #2 rst = 1'b1;
        #1 checkResetValues("rst_mid");
        shDig = '0; shDp = '0; shMask = '0;
        pendFull = 0; swPending = 0; xferArmed = 0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        tickUntil(45);

`ifdef SEG_SCAN_BRIGHT_EN
        begin
            int lit;
            lit = 0;
            applyStimulus(32'h00000000, 8'h00, 8'hFF);
            tick();
            enB = 1'b1;
            repeat (4) tick();
            for (int i = 0; i < 72; i++) begin
                tick();
                if (anNB !== 8'hFF) lit++;
            end
            checkOutput("bright3_duty", lit, 32'd32);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an 8-digit, common-anode, active-low seven-segment display. It owns the 3-bit digit select that feeds the board's 3-to-8 active-low digit decoder, and it drives active-low segment and decimal-point lines. Display contents arrive over a valid/ready update port into a pending buffer. The buffer commits to the shadow register only at a frame boundary, so a frame never tears. A blanking interval between digits suppresses ghosting.

Parameters:
CLK_DIV, 16, clock cycles each digit is shown (SHOW length); must be ≥1; multiple of 8 when SEG_SCAN_BRIGHT_EN is defined
BLANK_CYCLES, 2, all-off cycles before each digit; 0 means BLANK is skipped
NUM_DIGITS, 8, digits scanned, range 1..8; sel wraps at NUM_DIGITS-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  scan enable; low forces IDLE
upd_valid  in  1  update offer
upd_ready  out  1  high when pending buffer empty
upd_digits  in  32  hex nibble per digit; digit i = [4i+3:4i]
upd_dp  in  8  decimal point per digit, 1 = lit
upd_mask  in  8  digit enable per digit, 1 = shown
sel  out  3  current digit index, to the external decoder
an_n  out  8  active-low digit enables (internal decode of sel, gated)
seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
dp_n  out  1  active-low decimal point
frame_done  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset values (async, immediate): sel=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1, frame_done=0, upd_ready=1, pending cleared, shadow digits/dp/mask=0, state=IDLE, counters=0.
- All outputs are registered. They change one cycle after the state or counter change that causes them.
- States:
  - IDLE: outputs off. Moves to BLANK when en=1, or to SHOW if BLANK_CYCLES=0. sel=0.
  - BLANK: an_n=FF, seg_n=7F, dp_n=1 for BLANK_CYCLES cycles, then SHOW.
  - SHOW: lasts CLK_DIV cycles.
    - an_n = ~(1<<sel) if shadow mask[sel]=1, else FF.
    - seg_n = hex decode of the shadow nibble; dp_n = ~dp[sel].
    - On the last SHOW cycle, sel increments and the state returns to BLANK, or to SHOW if BLANK_CYCLES=0.
- Frame wrap: on the last SHOW cycle with sel=NUM_DIGITS-1:
  - sel goes to 0 and frame_done pulses for exactly that cycle.
  - If pending is full, shadow loads from pending, pending clears, and upd_ready returns to 1 the next cycle.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+CLK_DIV) cycles.
- Handshake:
  - A transfer occurs when upd_valid & upd_ready; payload is captured into pending and upd_ready drops the next cycle.
  - A transfer in the wrap cycle itself waits for the following wrap.
  - In IDLE a full pending buffer commits on the next cycle.
  - upd_valid while upd_ready=0 is ignored; the offerer must hold it.
- en falling in any state: IDLE on the next edge, outputs off, sel=0. Pending and shadow are retained.
- Hex decode (active low), examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110.

Optional Feature:
SEG_SCAN_BRIGHT_EN
- Defined:
  - Adds input bright[2:0].
  - In SHOW, an_n is asserted only while the SHOW counter's top-three-bit phase (counter*8/CLK_DIV) ≤ bright; otherwise an_n=FF.
  - bright=7 gives full on; bright=0 gives 1/8 duty.
  - Timing and frame_done are unchanged.
- Undefined: no port; full duty.

Decomposition:
- Package seg_scan_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_OFF=7'h7F
  - 16-entry hex-to-segment constant table
  - AN_OFF=8'hFF
- Sub-module hex_to_seg7: combinational nibble → active-low segments, reused by other display blocks.
- Counters, FSM and the pending/shadow buffers live in seg_scan_ctrl.

Test Plan:
- Reset, with CLK_DIV=4 and BLANK_CYCLES=1: assert rst → an_n=FF, seg_n=7F, dp_n=1, sel=0, upd_ready=1, frame_done=0, all without a clock edge.
- Basic scan:
  - Stimulus: in IDLE, push digits=32'h76543210, mask=FF, dp=01, then set en=1.
  - Digit 0 shows an_n=FE, seg_n=1000000, dp_n=0 for 4 cycles after 1 blank cycle.
  - Digit 1 shows an_n=FD, seg_n=1111001.
  - frame_done pulses every 40 cycles.
- Tear-free update:
  - Stimulus: push 32'h88888888 while sel=3.
  - upd_ready=0 the next cycle, and digits 4–7 still show their old values.
  - After frame_done, every digit shows seg_n=0000000 and upd_ready=1.
- Mask: mask=8'b00000101 → an_n asserted only in slots 0 and 2; slots 1 and 3–7 give an_n=FF; frame period is still 40.
- Mid-operation reset: assert rst during SHOW of digit 5 → immediate reset values. After release with en=1, the scan restarts at digit 0 showing hex 0 with an_n=FF (mask=0).
- en drop / brightness:
  - en=0 mid-SHOW → IDLE the next cycle with an_n=FF.
  - With SEG_SCAN_BRIGHT_EN, CLK_DIV=8 and bright=3: an_n is asserted for 4 of 8 SHOW cycles.
